// File: rtl/stq_dout_packer_pkg.sv
// Shared types and constants for the SpMV store-side packer.
// - elem_t      : one stream element, row index in the MSBs, value in the LSBs
// - PAD_ROW_IDX : row index written into unfilled slots of a padded word
// - slot_lsb(j) : LSB bit position of slot j (slot 0 sits at the MSB end)
package spmv_pack_pkg;

  localparam int unsigned STREAM_WIDTH     = 4;
  localparam int unsigned LOG_STREAM_WIDTH = 2;
  localparam int unsigned BITS_ROW_IDX     = 16;
  localparam int unsigned DATA_PRECISION   = 16;
  localparam int unsigned DATA_WIDTH       = BITS_ROW_IDX + DATA_PRECISION;
  localparam int unsigned LDQ_DATA_WIDTH   = STREAM_WIDTH * DATA_WIDTH;
  localparam int unsigned OUT_DEPTH        = 2;
  localparam logic        MODE_WORK        = 1'b1;

  typedef logic [BITS_ROW_IDX-1:0]     row_idx_t;
  typedef logic [LDQ_DATA_WIDTH-1:0]   word_t;
  typedef logic [LOG_STREAM_WIDTH-1:0] ptr_t;

  typedef struct packed {
    row_idx_t                  row_idx;
    logic [DATA_PRECISION-1:0] val;
  } elem_t;

  localparam row_idx_t PAD_ROW_IDX = '1;

  function automatic int unsigned slot_lsb(input int unsigned j);
    return LDQ_DATA_WIDTH - DATA_WIDTH * (j + 1);
  endfunction

endpackage

// File: rtl/stq_dout_packer_if.sv
// Element-in / word-out bus of the store-side packer.
// - din_valid/din/din_last/flush/din_ready : element stream from the merge network
// - stq_ready/stq_data_valid/stq_data/maxidx_out : packed words towards the store queue
// slave  : the packer
// master : the element producer / store-queue side
interface stq_dout_packer_if
  import spmv_pack_pkg::*;
();

  logic     din_valid;
  elem_t    din;
  logic     din_last;
  logic     flush;
  logic     din_ready;
  logic     stq_ready;
  logic     stq_data_valid;
  word_t    stq_data;
  row_idx_t maxidx_out;

  modport slave (
    input  din_valid, din, din_last, flush, stq_ready,
    output din_ready, stq_data_valid, stq_data, maxidx_out
  );

  modport master (
    output din_valid, din, din_last, flush, stq_ready,
    input  din_ready, stq_data_valid, stq_data, maxidx_out
  );

endinterface

// File: rtl/stq_dout_packer_word_fifo.sv
// Two-entry FIFO holding completed {word, maxidx} entries.
// - clk, rst : clock, asynchronous active-high reset
// - push/din : write one entry (ignored when full)
// - pop      : drop the head entry (ignored when empty)
// - dout     : head entry, zero after reset
// - count    : number of valid entries (0..2)
module stq_word_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok = push && (count_q != 2'd2);
    pop_ok  = pop && (count_q != 2'd0);
    mem_d   = mem_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
    end
    wr_d    = wr_q ^ push_ok;
    rd_d    = rd_q ^ pop_ok;
    count_d = count_q + 2'(push_ok) - 2'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/stq_dout_packer.sv
// Packs the sorted SpMV result stream, one element per cycle, into
// STREAM_WIDTH-element store-queue words (slot 0 at the MSB end), buffering
// up to two finished words against store-queue backpressure.
// - clk, rst  : clock, asynchronous active-high reset
// - unit_en   : unit enable; together with mode == MODE_WORK gates intake
// - mode      : operating mode
// - bus       : element stream in, packed words out (see stq_dout_packer_if)
// - order_err : sticky, row index went backwards inside one word
// - word_cnt  : words handed to the store queue, wraps at 2^32
module stq_dout_packer
  import spmv_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              unit_en,
  input  logic              mode,
  stq_dout_packer_if.slave  bus,
  output logic              order_err,
  output logic [31:0]       word_cnt
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_FILL   = 1'b1;
  localparam ptr_t       PTR_LAST  = ptr_t'(STREAM_WIDTH - 1);
  localparam logic [1:0] FIFO_FULL = 2'(OUT_DEPTH);
  localparam elem_t      PAD_ELEM  = '{row_idx: PAD_ROW_IDX, val: '0};

  logic [0:0]  state_q, state_d;
  ptr_t        ptr_q, ptr_d;
  word_t       asm_q, asm_d;
  row_idx_t    last_row_q, last_row_d;
  logic        order_err_q, order_err_d;
  logic [31:0] word_cnt_q, word_cnt_d;

  logic        global_en;
  logic        din_ready;
  logic        accept;
  logic        close_elem;
  logic        close_flush;
  logic        push;
  logic        pop;
  word_t       push_word;
  row_idx_t    push_maxidx;
  logic [1:0]  fifo_count;
  logic [LDQ_DATA_WIDTH+BITS_ROW_IDX-1:0] fifo_dout;

  always_comb begin
    global_en = unit_en && (mode == MODE_WORK);
    din_ready = global_en && (fifo_count < FIFO_FULL);
    accept    = bus.din_valid && din_ready;
    // flush on an accepted element simply marks it as the word's last element
    close_elem  = accept && ((ptr_q == PTR_LAST) || bus.din_last || bus.flush);
    // a stand-alone flush needs FIFO room, otherwise it is dropped
    close_flush = !accept && bus.flush && din_ready && (state_q == ST_FILL);
    push = close_elem || close_flush;
    pop  = (fifo_count != 2'd0) && bus.stq_ready;

    // word as it stands after this cycle: filled slots, new element, then padding
    push_word = '0;
    for (int unsigned j = 0; j < STREAM_WIDTH; j++) begin
      if (j < 32'(ptr_q)) begin
        push_word[slot_lsb(j) +: DATA_WIDTH] = asm_q[slot_lsb(j) +: DATA_WIDTH];
      end else if (accept && (j == 32'(ptr_q))) begin
        push_word[slot_lsb(j) +: DATA_WIDTH] = bus.din;
      end else begin
        push_word[slot_lsb(j) +: DATA_WIDTH] = PAD_ELEM;
      end
    end
    push_maxidx = accept ? bus.din.row_idx : last_row_q;

    state_d     = state_q;
    ptr_d       = ptr_q;
    asm_d       = asm_q;
    last_row_d  = last_row_q;
    order_err_d = order_err_q;

    if (accept && (state_q == ST_FILL) && (bus.din.row_idx < last_row_q)) begin
      order_err_d = 1'b1;
    end

    if (push) begin
      state_d = ST_IDLE;
      ptr_d   = '0;
      asm_d   = '0;
    end else if (accept) begin
      state_d    = ST_FILL;
      ptr_d      = ptr_q + ptr_t'(1);
      asm_d      = push_word;
      last_row_d = bus.din.row_idx;
    end

    word_cnt_d = word_cnt_q + 32'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      asm_q       <= '0;
      last_row_q  <= '0;
      order_err_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      asm_q       <= asm_d;
      last_row_q  <= last_row_d;
      order_err_q <= order_err_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  stq_word_fifo #(
    .WIDTH (LDQ_DATA_WIDTH + BITS_ROW_IDX)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({push_word, push_maxidx}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign bus.din_ready      = din_ready;
  assign bus.stq_data_valid = (fifo_count != 2'd0);
  assign bus.stq_data       = fifo_dout[LDQ_DATA_WIDTH+BITS_ROW_IDX-1:BITS_ROW_IDX];
  assign bus.maxidx_out     = fifo_dout[BITS_ROW_IDX-1:0];
  assign order_err          = order_err_q;
  assign word_cnt           = word_cnt_q;

endmodule
